div_32by16_seq: RTL

Sequential restoring divider: 2N-bit dividend by N-bit divisor, producing an N-bit quotient and N-bit remainder, one quotient bit per cycle. It is the inverse datapath to the pipelined 16x16 Dadda multiplier. Feeding it a 32-bit product and one 16-bit operand recovers the other operand with a zero remainder. It sits behind the multiplier in the arithmetic unit and uses valid/ready handshakes on both sides.

---
 rtl/div_32by16_seq_pkg.sv | 22 ++
 rtl/div_32by16_seq_if.sv | 31 +++
 rtl/div_32by16_seq_step.sv | 28 ++
 rtl/div_32by16_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/div_32by16_seq_pkg.sv
// Shared constants and types for the sequential 2N/N restoring divider.
// Latency: none (package only).
// Backpressure: none (package only).
package div_pkg;

  localparam int DIV_N  = 16;
  localparam int DIV_DW = 2 * DIV_N;

  // Iteration counter width for a given quotient width.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DIV_CW = cnt_w(DIV_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_32by16_seq_if.sv
// Operand/result handshake bundle between the arithmetic unit and the divider.
// Latency: wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface div_32by16_seq_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             ovf;
  logic             dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dz
  );

endinterface

// File: rtl/div_32by16_seq_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_rem,
  output logic         o_qbit
);

  logic [N+1:0] w_shift;
  logic [N+1:0] w_trial;

  // Partial remainder stays below the divisor, so i_rem[N] is zero and the
  // full-width shift equals {r[N-1:0], bit}; a clear sign bit means the subtract fits.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_trial = w_shift - {2'b00, i_divisor};
    o_qbit  = ~w_trial[N+1];
    o_rem   = o_qbit ? w_trial[N:0] : w_shift[N:0];
  end

endmodule

// File: rtl/div_32by16_seq.sv
// Sequential restoring divider: 2N-bit unsigned dividend / N-bit divisor, one quotient bit per cycle.
// Latency: N+1 edges accept-to-result (2 on overflow/divide-by-zero); result held in DONE.
// Backpressure: accepts only in IDLE; result registers frozen until out_ready consumes them.
module div_32by16_seq
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic             clk,
  input  logic             rst,
  div_32by16_seq_if.slave  bus
);

  localparam int CW = cnt_w(N);

  div_state_t     r_state;
  div_state_t     w_state_next;

  logic [N-1:0]   r_div;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_sh;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf_pend;
  logic           r_dz_pend;

  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_remo;
  logic           r_ovf;
  logic           r_dz;

  logic [N:0]     w_rem_next;
  logic           w_qbit;
  logic           w_last;
  logic           w_ovf_in;

  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_ovf_in = (bus.dividend[2*N-1:N] >= bus.divisor);

  div_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_sh[N-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode; an overflowing operation spends one cycle in CALC so
  // every result is loaded from the same place on the CALC->DONE edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = CALC;
      CALC:    if (r_ovf_pend || w_last) w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div      <= '0;
      r_rem      <= '0;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_quot     <= '0;
      r_remo     <= '0;
      r_ovf      <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_div      <= bus.divisor;
            r_rem      <= {1'b0, bus.dividend[2*N-1:N]};
            r_sh       <= bus.dividend[N-1:0];
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_in;
            r_dz_pend  <= (bus.divisor == '0);
          end
        end
        CALC: begin
          if (r_ovf_pend) begin
            r_quot <= '1;
            r_remo <= '0;
            r_ovf  <= 1'b1;
            r_dz   <= r_dz_pend;
          end else begin
            r_rem <= w_rem_next;
            r_sh  <= {r_sh[N-2:0], w_qbit};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_quot <= {r_sh[N-2:0], w_qbit};
              r_remo <= w_rem_next[N-1:0];
              r_ovf  <= 1'b0;
              r_dz   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remo;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;

endmodule
